ctrl_pipe: RTL and testbench

- Carries the packed 8-bit control bundle and the branch/jump indications from the main decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
- Unpacks the bundle per stage.
- Generates the load-use stall, the IF/ID flush and the EX-stage forwarding selects.
- Sits between the decoder output and the datapath muxes, register file and data memory.

---
 rtl/ctrl_pipe.sv | 142 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control pipeline for the 5-stage MIPS core: carries decoder control through ID/EX, EX/MEM
// and MEM/WB, and derives the load-use stall, IF/ID flush and EX-stage forwarding selects.
module ctrl_pipe (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ctrl_i,
    input  logic       branch_taken_i,
    input  logic       jump_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic [4:0] id_rd_i,
    output logic       stall_o,
    output logic       ifid_flush_o,
    output logic       ex_alusrc_o,
    output logic [1:0] ex_aluop_o,
    output logic [1:0] ex_fwd_a_o,
    output logic [1:0] ex_fwd_b_o,
    output logic       mem_memread_o,
    output logic       mem_memwrite_o,
    output logic       mem_regwrite_o,
    output logic [4:0] mem_wr_o,
    output logic       wb_regwrite_o,
    output logic       wb_memtoreg_o,
    output logic [4:0] wb_wr_o
);

    // ID/EX state
    logic [7:0] ex_ctrl;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;

    // EX/MEM state
    logic       mem_regwrite;
    logic       mem_memtoreg;
    logic       mem_memread;
    logic       mem_memwrite;
    logic [4:0] mem_wr;

    // MEM/WB state
    logic       wb_regwrite;
    logic       wb_memtoreg;
    logic [4:0] wb_wr;

    // EX-stage unpacked bundle
    logic       ex_regwrite;
    logic       ex_memtoreg;
    logic       ex_memread;
    logic       ex_memwrite;
    logic       ex_alusrc;
    logic [1:0] ex_aluop;
    logic       ex_regdst;
    logic [4:0] ex_wr;
    logic       stall;

    assign ex_regwrite = ex_ctrl[7];
    assign ex_memtoreg = ex_ctrl[6];
    assign ex_memread  = ex_ctrl[5];
    assign ex_memwrite = ex_ctrl[4];
    assign ex_alusrc   = ex_ctrl[3];
    assign ex_aluop    = ex_ctrl[2:1];
    assign ex_regdst   = ex_ctrl[0];
    assign ex_wr       = ex_regdst ? ex_rd : ex_rt;

    // EX/MEM wins over MEM/WB so the youngest producer is forwarded; $0 never matches.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       m_rw,
                                           input logic [4:0] m_wr,
                                           input logic       w_rw,
                                           input logic [4:0] w_wr);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_rw && (m_wr != 5'd0) && (m_wr == src)) begin
            sel = 2'b10;
        end else if (w_rw && (w_wr != 5'd0) && (w_wr == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        stall = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs_i) || (ex_rt == id_rt_i));
    end

    assign stall_o      = stall;
    assign ifid_flush_o = (branch_taken_i | jump_i) & ~stall;
    assign ex_alusrc_o  = ex_alusrc;
    assign ex_aluop_o   = ex_aluop;
    assign ex_fwd_a_o   = fwd_sel(ex_rs, mem_regwrite, mem_wr, wb_regwrite, wb_wr);
    assign ex_fwd_b_o   = fwd_sel(ex_rt, mem_regwrite, mem_wr, wb_regwrite, wb_wr);

    assign mem_memread_o  = mem_memread;
    assign mem_memwrite_o = mem_memwrite;
    assign mem_regwrite_o = mem_regwrite;
    assign mem_wr_o       = mem_wr;
    assign wb_regwrite_o  = wb_regwrite;
    assign wb_memtoreg_o  = wb_memtoreg;
    assign wb_wr_o        = wb_wr;

    // A stall injects an all-zero bubble; the stalled instruction re-presents from IF/ID.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_ctrl <= 8'd0;
            ex_rs   <= 5'd0;
            ex_rt   <= 5'd0;
            ex_rd   <= 5'd0;
        end else if (stall) begin
            ex_ctrl <= 8'd0;
            ex_rs   <= 5'd0;
            ex_rt   <= 5'd0;
            ex_rd   <= 5'd0;
        end else begin
            ex_ctrl <= ctrl_i;
            ex_rs   <= id_rs_i;
            ex_rt   <= id_rt_i;
            ex_rd   <= id_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_wr       <= 5'd0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_wr        <= 5'd0;
        end else begin
            mem_regwrite <= ex_regwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_wr       <= ex_wr;
            wb_regwrite  <= mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_wr        <= mem_wr;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a per-cycle vector table through a short program, plus
// hand-written reset/latency and asynchronous-reset sequences.
module tb_ctrl_pipe;

    // Bundle {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}
    localparam logic [7:0] NOP  = 8'b0000_0000;
    localparam logic [7:0] RTY  = 8'b1000_0101;
    localparam logic [7:0] LW   = 8'b1110_1000;
    localparam logic [7:0] SW   = 8'b0001_1000;
    localparam logic [7:0] ADDI = 8'b1000_1000;
    localparam logic [7:0] BEQ  = 8'b0000_0010;
    localparam int NVEC = 22;

    typedef struct {
        logic [7:0]  ctrl;
        logic        br;
        logic        jmp;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [23:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ctrl = 8'd0;
    logic       br = 1'b0;
    logic       jmp = 1'b0;
    logic [4:0] rs = 5'd0;
    logic [4:0] rt = 5'd0;
    logic [4:0] rd = 5'd0;

    logic       stall, flush, alusrc, mem_memread, mem_memwrite, mem_regwrite;
    logic       wb_regwrite, wb_memtoreg;
    logic [1:0] aluop, fwd_a, fwd_b;
    logic [4:0] mem_wr, wb_wr;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[NVEC];

    ctrl_pipe dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ctrl_i         (ctrl),
        .branch_taken_i (br),
        .jump_i         (jmp),
        .id_rs_i        (rs),
        .id_rt_i        (rt),
        .id_rd_i        (rd),
        .stall_o        (stall),
        .ifid_flush_o   (flush),
        .ex_alusrc_o    (alusrc),
        .ex_aluop_o     (aluop),
        .ex_fwd_a_o     (fwd_a),
        .ex_fwd_b_o     (fwd_b),
        .mem_memread_o  (mem_memread),
        .mem_memwrite_o (mem_memwrite),
        .mem_regwrite_o (mem_regwrite),
        .mem_wr_o       (mem_wr),
        .wb_regwrite_o  (wb_regwrite),
        .wb_memtoreg_o  (wb_memtoreg),
        .wb_wr_o        (wb_wr)
    );

    always #5 clk = ~clk;

    // Expected output word: {stall, flush, alusrc, aluop, fwd_a, fwd_b,
    //                        mem_memread, mem_memwrite, mem_regwrite, mem_wr,
    //                        wb_regwrite, wb_memtoreg, wb_wr}
    function automatic logic [23:0] ex_word(input logic st, fl, als, input logic [1:0] aop, fa,
                                            fb, input logic mr, mw, mrw, input logic [4:0] mwr,
                                            input logic wrw, wmt, input logic [4:0] wwr);
        return {st, fl, als, aop, fa, fb, mr, mw, mrw, mwr, wrw, wmt, wwr};
    endfunction

    function automatic vec_t mk(input logic [7:0] c, input logic b, j,
                                input logic [4:0] s, t, d, input logic [23:0] e);
        vec_t v;
        v.ctrl = c; v.br = b; v.jmp = j; v.rs = s; v.rt = t; v.rd = d; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [23:0] exp);
        logic [23:0] act;
        act = {stall, flush, alusrc, aluop, fwd_a, fwd_b, mem_memread, mem_memwrite,
               mem_regwrite, mem_wr, wb_regwrite, wb_memtoreg, wb_wr};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic b, j, input logic [4:0] s, t, d);
        ctrl = c; br = b; jmp = j; rs = s; rt = t; rd = d;
    endtask

    initial begin
        // Program: add $3,$1,$2 / add $4,$3,$3 / nop / add $5,$4,$4 / lw $5 / use $5 (x2) /
        // addi $0 / use $0 / lw $0 / use $0 / beq / lw $9 / beq-with-use (x2) / j /
        // lw $10 / lw $11,($10) (x2) / add uses $11 (x2) / nop
        vecs[0]  = mk(RTY, 0, 0, 1, 2, 3,   ex_word(0,0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0));
        vecs[1]  = mk(RTY, 0, 0, 3, 3, 4,   ex_word(0,0,0,2'b10,2'b00,2'b00,0,0,0,0,0,0,0));
        vecs[2]  = mk(NOP, 0, 0, 0, 0, 0,   ex_word(0,0,0,2'b10,2'b10,2'b10,0,0,1,3,0,0,0));
        vecs[3]  = mk(RTY, 0, 0, 4, 4, 5,   ex_word(0,0,0,2'b00,2'b00,2'b00,0,0,1,4,1,0,3));
        vecs[4]  = mk(LW,  0, 0, 1, 5, 0,   ex_word(0,0,0,2'b10,2'b01,2'b01,0,0,0,0,1,0,4));
        vecs[5]  = mk(RTY, 0, 0, 5, 0, 6,   ex_word(1,0,1,2'b00,2'b00,2'b10,0,0,1,5,0,0,0));
        vecs[6]  = mk(RTY, 0, 0, 5, 0, 6,   ex_word(0,0,0,2'b00,2'b00,2'b00,1,0,1,5,1,0,5));
        vecs[7]  = mk(ADDI,0, 0, 1, 0, 0,   ex_word(0,0,0,2'b10,2'b01,2'b00,0,0,0,0,1,1,5));
        vecs[8]  = mk(RTY, 0, 0, 0, 0, 7,   ex_word(0,0,1,2'b00,2'b00,2'b00,0,0,1,6,0,0,0));
        vecs[9]  = mk(LW,  0, 0, 1, 0, 0,   ex_word(0,0,0,2'b10,2'b00,2'b00,0,0,1,0,1,0,6));
        vecs[10] = mk(RTY, 0, 0, 0, 0, 8,   ex_word(0,0,1,2'b00,2'b00,2'b00,0,0,1,7,1,0,0));
        vecs[11] = mk(BEQ, 1, 0, 1, 2, 0,   ex_word(0,1,0,2'b10,2'b00,2'b00,1,0,1,0,1,0,7));
        vecs[12] = mk(LW,  0, 0, 2, 9, 0,   ex_word(0,0,0,2'b01,2'b00,2'b00,0,0,1,8,1,1,0));
        vecs[13] = mk(BEQ, 1, 0, 9, 3, 0,   ex_word(1,0,1,2'b00,2'b00,2'b00,0,0,0,2,1,0,8));
        vecs[14] = mk(BEQ, 1, 0, 9, 3, 0,   ex_word(0,1,0,2'b00,2'b00,2'b00,1,0,1,9,0,0,2));
        vecs[15] = mk(NOP, 0, 1, 0, 0, 0,   ex_word(0,1,0,2'b01,2'b01,2'b00,0,0,0,0,1,1,9));
        vecs[16] = mk(LW,  0, 0, 1, 10, 0,  ex_word(0,0,0,2'b00,2'b00,2'b00,0,0,0,3,0,0,0));
        vecs[17] = mk(LW,  0, 0, 10, 11, 0, ex_word(1,0,1,2'b00,2'b00,2'b00,0,0,0,0,0,0,3));
        vecs[18] = mk(LW,  0, 0, 10, 11, 0, ex_word(0,0,0,2'b00,2'b00,2'b00,1,0,1,10,0,0,0));
        vecs[19] = mk(RTY, 0, 0, 11, 0, 12, ex_word(1,0,1,2'b00,2'b01,2'b00,0,0,0,0,1,1,10));
        vecs[20] = mk(RTY, 0, 0, 11, 0, 12, ex_word(0,0,0,2'b00,2'b00,2'b00,1,0,1,11,0,0,0));
        vecs[21] = mk(NOP, 0, 0, 0, 0, 0,   ex_word(0,0,0,2'b10,2'b01,2'b00,0,0,0,0,1,1,11));

        // Reset, idle: everything 0 except flush, which follows its inputs.
        #12;
        check("reset_idle", 24'd0);
        br = 1'b1;
        #1 check("reset_flush_follows", ex_word(0,1,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0));
        br = 1'b0;
        #2 rst = 1'b1;

        // R-type latency: ex after 1 edge, mem after 2, wb after 3.
        @(posedge clk); #1 drive(RTY, 0, 0, 0, 0, 3);
        @(posedge clk); #1 drive(NOP, 0, 0, 0, 0, 0);
        #1 check("rtype_ex", ex_word(0,0,0,2'b10,2'b00,2'b00,0,0,0,0,0,0,0));
        @(posedge clk); #2 check("rtype_mem", ex_word(0,0,0,2'b00,2'b00,2'b00,0,0,1,3,0,0,0));
        @(posedge clk); #2 check("rtype_wb", ex_word(0,0,0,2'b00,2'b00,2'b00,0,0,0,0,1,0,3));

        // Restart empty for the table.
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1 drive(vecs[i].ctrl, vecs[i].br, vecs[i].jmp,
                                     vecs[i].rs, vecs[i].rt, vecs[i].rd);
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // sw in MEM and lw in EX, then asynchronous reset mid-cycle.
        @(posedge clk); #1 drive(SW, 0, 0, 1, 6, 0);
        @(posedge clk); #1 drive(LW, 0, 0, 1, 5, 0);
        @(posedge clk); #1 drive(NOP, 0, 0, 0, 0, 0);
        #1 check("pre_reset", ex_word(0,0,1,2'b00,2'b00,2'b00,0,1,0,6,0,0,0));
        @(posedge clk); #1 drive(NOP, 0, 0, 0, 0, 0);
        #1 check("pre_reset_lw_mem", ex_word(0,0,0,2'b00,2'b00,2'b00,1,0,1,5,0,0,6));
        #1 rst = 1'b0;
        #1 check("async_reset", 24'd0);
        #3 rst = 1'b1;
        @(posedge clk); #2 check("restart_1", 24'd0);
        @(posedge clk); #2 check("restart_2", 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
